pipe_addsub: RTL

- Parametrised, pipelined N-bit adder/subtractor; successor to the combinational cla_add.
- Splits the carry chain into CHUNK-bit stages, one register stage per chunk.
- Adds a subtract mode, carry-out, zero flag and a valid/ready handshake with backpressure.
- Serves as the ALU arithmetic path in the rv32 core and as a stand-alone streaming arithmetic unit.

---
 rtl/addsub_pkg.sv | 22 ++
 rtl/pipe_addsub_if.sv | 32 +++
 rtl/addsub_stage.sv | 91 +++++++++
 rtl/pipe_addsub.sv | 69 ++++++
 4 files changed

// File: rtl/addsub_pkg.sv
// Shared definitions for the pipelined adder/subtractor.
//   OP_ADD / OP_SUB : encoding of the in_op port.
//   stage_meta_t    : per-beat side-band bits that travel with each stage's
//                     payload. These are the chunk carry and the operand sign
//                     bits that the final overflow decision needs.
//   calc_stages()   : number of pipeline stages for a given width and chunk.
package addsub_pkg;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  typedef struct packed {
    logic carry;  // carry out of the most recently resolved chunk
    logic a_msb;  // a[N-1], kept after the operand bit itself is consumed
    logic b_msb;  // b_eff[N-1], likewise
  } stage_meta_t;

  function automatic int calc_stages(input int n, input int chunk);
    return n / chunk;
  endfunction

endpackage

// File: rtl/pipe_addsub_if.sv
// Streaming operand/result bundle of pipe_addsub.
//   in_valid/in_ready/in_op/in_a/in_b      : operand beat (producer -> unit)
//   out_valid/out_ready/out_sum/out_cout/
//   out_ovf/out_zero                       : result beat (unit -> consumer)
// master = producer/consumer side, slave = the arithmetic unit.
interface pipe_addsub_if #(
  parameter int N = 32
);

  logic         in_valid;
  logic         in_ready;
  logic         in_op;
  logic [N-1:0] in_a;
  logic [N-1:0] in_b;
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] out_sum;
  logic         out_cout;
  logic         out_ovf;
  logic         out_zero;

  modport master (
    output in_valid, in_op, in_a, in_b, out_ready,
    input  in_ready, out_valid, out_sum, out_cout, out_ovf, out_zero
  );

  modport slave (
    input  in_valid, in_op, in_a, in_b, out_ready,
    output in_ready, out_valid, out_sum, out_cout, out_ovf, out_zero
  );

endinterface

// File: rtl/addsub_stage.sv
// One pipeline stage of pipe_addsub: resolves chunk K of the sum and
// registers the result together with its valid bit.
//   clk, rst_n        : clock, async active-low reset
//   i_valid           : upstream stage (or producer) holds a beat
//   o_ready           : this stage advances this cycle (its adv bit)
//   i_next_ready      : downstream stage advances (or consumer accepts)
//   i_sum/i_a/i_b     : partial sum and not-yet-consumed operand bits
//   i_meta            : incoming carry and operand sign bits
//   o_valid, o_sum, o_a, o_b, o_meta : registered payload for the next stage
module addsub_stage
  import addsub_pkg::*;
#(
  parameter int N     = 32,
  parameter int CHUNK = 8,
  parameter int K     = 0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_valid,
  output logic         o_ready,
  input  logic         i_next_ready,
  input  logic [N-1:0] i_sum,
  input  logic [N-1:0] i_a,
  input  logic [N-1:0] i_b,
  input  stage_meta_t  i_meta,
  output logic         o_valid,
  output logic [N-1:0] o_sum,
  output logic [N-1:0] o_a,
  output logic [N-1:0] o_b,
  output stage_meta_t  o_meta
);

  localparam int           LO         = K * CHUNK;
  localparam logic [N-1:0] CHUNK_MASK = N'({CHUNK{1'b1}}) << LO;

  logic              w_adv;
  logic [CHUNK:0]    w_slice;
  logic [N-1:0]      w_sum_nxt;
  logic [N-1:0]      w_a_nxt;
  logic [N-1:0]      w_b_nxt;

  logic              r_valid;
  logic [N-1:0]      r_sum;
  logic [N-1:0]      r_a;
  logic [N-1:0]      r_b;
  stage_meta_t       r_meta;

  // An empty stage always takes a beat, so bubbles collapse under stall.
  assign w_adv   = !r_valid || i_next_ready;
  assign o_ready = w_adv;

  assign w_slice = {1'b0, i_a[LO +: CHUNK]} + {1'b0, i_b[LO +: CHUNK]}
                 + {{CHUNK{1'b0}}, i_meta.carry};

  // Chunk K of the incoming partial sum is still zero, so OR-ing the new
  // chunk in is an insert; consumed operand bits are cleared so the
  // registers only carry bits that later stages still need.
  assign w_sum_nxt = i_sum | (N'(w_slice[CHUNK-1:0]) << LO);
  assign w_a_nxt   = i_a & ~CHUNK_MASK;
  assign w_b_nxt   = i_b & ~CHUNK_MASK;

  // NOTE: every register here is written with <= so all stages sample the
  // previous stage's value from before the edge; blocking writes would let a
  // beat race through several stages in one cycle.
  // NOTE: the payload registers are reset along with the valid bit so the
  // result bus reads zero out of reset instead of power-up garbage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_sum   <= '0;
      r_a     <= '0;
      r_b     <= '0;
      r_meta  <= '0;
    end else if (w_adv) begin
      r_valid <= i_valid;
      if (i_valid) begin
        r_sum  <= w_sum_nxt;
        r_a    <= w_a_nxt;
        r_b    <= w_b_nxt;
        r_meta <= '{carry: w_slice[CHUNK], a_msb: i_meta.a_msb, b_msb: i_meta.b_msb};
      end
    end
  end

  assign o_valid = r_valid;
  assign o_sum   = r_sum;
  assign o_a     = r_a;
  assign o_b     = r_b;
  assign o_meta  = r_meta;

endmodule

// File: rtl/pipe_addsub.sv
// Pipelined N-bit adder/subtractor with valid/ready backpressure.
// The carry chain is split into CHUNK-bit slices, one register stage each.
//   clk, rst_n : clock, async active-low reset
//   bus        : pipe_addsub_if slave port (operand beat in, result beat out)
// Only out_ready -> in_ready is combinational (through the advance chain).
module pipe_addsub
  import addsub_pkg::*;
#(
  parameter int N     = 32,
  parameter int CHUNK = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  pipe_addsub_if.slave  bus
);

  localparam int STAGES = calc_stages(N, CHUNK);

  // Index k is the input of stage k; index STAGES is the final result.
  logic         w_valid [STAGES+1];
  logic         w_ready [STAGES+1];
  logic [N-1:0] w_sum   [STAGES+1];
  logic [N-1:0] w_a     [STAGES+1];
  logic [N-1:0] w_b     [STAGES+1];
  stage_meta_t  w_meta  [STAGES+1];

  // Subtract is a + ~b + 1: invert b and feed the 1 in as carry-in.
  assign w_valid[0] = bus.in_valid;
  assign w_sum[0]   = '0;
  assign w_a[0]     = bus.in_a;
  assign w_b[0]     = (bus.in_op == OP_SUB) ? ~bus.in_b : bus.in_b;
  assign w_meta[0]  = '{carry: bus.in_op, a_msb: bus.in_a[N-1], b_msb: w_b[0][N-1]};

  assign w_ready[STAGES] = bus.out_ready;
  assign bus.in_ready    = w_ready[0];

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    addsub_stage #(
      .N     (N),
      .CHUNK (CHUNK),
      .K     (k)
    ) u_stage (
      .clk          (clk),
      .rst_n        (rst_n),
      .i_valid      (w_valid[k]),
      .o_ready      (w_ready[k]),
      .i_next_ready (w_ready[k+1]),
      .i_sum        (w_sum[k]),
      .i_a          (w_a[k]),
      .i_b          (w_b[k]),
      .i_meta       (w_meta[k]),
      .o_valid      (w_valid[k+1]),
      .o_sum        (w_sum[k+1]),
      .o_a          (w_a[k+1]),
      .o_b          (w_b[k+1]),
      .o_meta       (w_meta[k+1])
    );
  end

  assign bus.out_valid = w_valid[STAGES];
  assign bus.out_sum   = w_sum[STAGES];
  assign bus.out_cout  = w_meta[STAGES].carry;
  assign bus.out_ovf   = (w_meta[STAGES].a_msb == w_meta[STAGES].b_msb)
                      && (w_sum[STAGES][N-1] != w_meta[STAGES].a_msb);
  // Qualified by valid so the flag reads 0 on an empty (reset) pipe even
  // though the cleared sum register is all zeros.
  assign bus.out_zero  = w_valid[STAGES] && ~|w_sum[STAGES];

endmodule
